// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : fb_scanout
//  Description : Pixel-fetch stage behind the display controller. Turns the
//                controller's counters into read addresses for a 200x150
//                RGB444 double-buffered framebuffer. Each stored row is
//                repeated VREP times. Sync and display are delayed so that
//                they stay aligned with the RAM read data. The block drives
//                blanked RGB and sync to the VGA pins.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_scanout #(
    parameter int FB_W       = 200,
    parameter int FB_H       = 150,
    parameter int VREP       = 4,
    parameter int V_VIS      = 600,
    parameter int H_FINISH   = 264,
    parameter int V_FINISH   = 628,
    parameter int COL_OFFSET = 1,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        hcounter,
    input  logic [10:0]       vcounter,
    input  logic              display,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              buf_sel,
    output logic [ADDR_W:0]   fb_addr,
    output logic              fb_rd_en,
    input  logic [11:0]       fb_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start,
    output logic              active_bank
);

    // The delay line holds one stage for the address register and RD_LAT
    // stages for the RAM. The output register follows, so the total latency
    // is RD_LAT+2 cycles.
    localparam int c_PIPE_DEPTH = RD_LAT + 1;
    localparam int c_ROW_W      = $clog2(FB_H + 1);
    localparam int c_REP_W      = (VREP > 1) ? $clog2(VREP) : 1;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_rd_lat_check
        $error("fb_scanout: RD_LAT must be in the range 1..4");
    end

    // ------------------------------------------------------------------
    // Line / row tracking
    // ------------------------------------------------------------------
    logic                    w_eol;
    logic                    w_frame_end;
    logic                    w_row_ok;
    logic                    w_row_step;
    logic [ADDR_W-1:0]       r_line_base;
    logic [c_REP_W-1:0]      r_rep;
    logic [c_ROW_W-1:0]      r_row;
    logic                    r_synced;

    assign w_eol       = (hcounter == 9'(H_FINISH));
    assign w_frame_end = w_eol && (vcounter == 11'(V_FINISH));
    assign w_row_ok    = (r_row < c_ROW_W'(FB_H));
    // Only visible lines advance the row. Once row reaches FB_H, it
    // saturates and line_base stops growing.
    assign w_row_step  = w_eol && (vcounter < 11'(V_VIS)) && w_row_ok;

    // Row/repeat counters and frame-boundary bookkeeping (bank latch, sync flag)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_base <= '0;
            r_rep       <= '0;
            r_row       <= '0;
            r_synced    <= 1'b0;
            active_bank <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_end;
            if (w_frame_end) begin
                r_line_base <= '0;
                r_rep       <= '0;
                r_row       <= '0;
                r_synced    <= 1'b1;
                active_bank <= buf_sel;
            end else if (w_row_step) begin
                if (r_rep == c_REP_W'(VREP - 1)) begin
                    r_rep       <= '0;
                    r_row       <= r_row + 1'b1;
                    r_line_base <= r_line_base + ADDR_W'(FB_W);
                end else begin
                    r_rep <= r_rep + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: column decode and address generation
    // ------------------------------------------------------------------
    // The column is a 10-bit two's-complement value. Bit 9 set means the
    // column is left of the image. Testing bit 9 and doing an unsigned
    // compare against FB_W rejects both edges without clamping.
    logic [9:0]              w_col;
    logic                    w_col_ok;
    logic                    w_rd_en;
    logic [ADDR_W-1:0]       w_pix_addr;

    assign w_col      = {1'b0, hcounter} - 10'(COL_OFFSET);
    assign w_col_ok   = !w_col[9] && (w_col < 10'(FB_W));
    assign w_rd_en    = display && r_synced && w_col_ok && w_row_ok;
    assign w_pix_addr = r_line_base + ADDR_W'(w_col);

    // Address and read-strobe register; the address holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_rd_en <= 1'b0;
            fb_addr  <= '0;
        end else begin
            fb_rd_en <= w_rd_en;
            if (w_rd_en) begin
                fb_addr <= {active_bank, w_pix_addr};
            end
        end
    end

    // ------------------------------------------------------------------
    // Delay line for the control signals, matched to the RAM latency
    // ------------------------------------------------------------------
    logic [c_PIPE_DEPTH-1:0] r_disp_pipe;
    logic [c_PIPE_DEPTH-1:0] r_rd_pipe;
    logic [c_PIPE_DEPTH-1:0] r_hs_pipe;
    logic [c_PIPE_DEPTH-1:0] r_vs_pipe;

    // Shift the display, read-enable and sync signals alongside the RAM access
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_pipe <= '0;
            r_rd_pipe   <= '0;
            r_hs_pipe   <= '1;
            r_vs_pipe   <= '1;
        end else begin
            r_disp_pipe <= {r_disp_pipe[c_PIPE_DEPTH-2:0], display};
            r_rd_pipe   <= {r_rd_pipe[c_PIPE_DEPTH-2:0], w_rd_en};
            r_hs_pipe   <= {r_hs_pipe[c_PIPE_DEPTH-2:0], hsync_in};
            r_vs_pipe   <= {r_vs_pipe[c_PIPE_DEPTH-2:0], vsync_in};
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic                    w_pix_on;

    assign w_pix_on = r_rd_pipe[c_PIPE_DEPTH-1] && r_disp_pipe[c_PIPE_DEPTH-1];

    // Blank RGB unless a real read is arriving; register syncs in the same stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r     <= 4'h0;
            vga_g     <= 4'h0;
            vga_b     <= 4'h0;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            if (w_pix_on) begin
                vga_r <= fb_data[11:8];
                vga_g <= fb_data[7:4];
                vga_b <= fb_data[3:0];
            end else begin
                vga_r <= 4'h0;
                vga_g <= 4'h0;
                vga_b <= 4'h0;
            end
            vga_hsync <= r_hs_pipe[c_PIPE_DEPTH-1];
            vga_vsync <= r_vs_pipe[c_PIPE_DEPTH-1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_scanout
//  Description : Self-checking bench for fb_scanout. Three instances are built
//                with RD_LAT 1, 2 and 4. Each has a RAM model that returns
//                address[11:0].
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_scanout;

    localparam int N_INST = 3;

    logic        clk;
    logic        rst;
    logic [8:0]  hcounter;
    logic [10:0] vcounter;
    logic        display;
    logic        hsync_in;
    logic        vsync_in;
    logic        buf_sel;

    logic [15:0] fa  [N_INST];
    logic        fre [N_INST];
    logic [11:0] fd  [N_INST];
    logic [3:0]  vr  [N_INST];
    logic [3:0]  vg  [N_INST];
    logic [3:0]  vb  [N_INST];
    logic        vh  [N_INST];
    logic        vv  [N_INST];
    logic        fs  [N_INST];
    logic        ab  [N_INST];

    int lat_of [N_INST] = '{1, 2, 4};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        logic [11:0] ram_pipe [L];

        fb_scanout #(.RD_LAT(L)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .hcounter    (hcounter),
            .vcounter    (vcounter),
            .display     (display),
            .hsync_in    (hsync_in),
            .vsync_in    (vsync_in),
            .buf_sel     (buf_sel),
            .fb_addr     (fa[g]),
            .fb_rd_en    (fre[g]),
            .fb_data     (fd[g]),
            .vga_r       (vr[g]),
            .vga_g       (vg[g]),
            .vga_b       (vb[g]),
            .vga_hsync   (vh[g]),
            .vga_vsync   (vv[g]),
            .frame_start (fs[g]),
            .active_bank (ab[g])
        );

        // RAM with L cycles of read latency; the data is the low 12 address bits
        always @(posedge clk) begin
            ram_pipe[0] <= fa[g][11:0];
            for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
        assign fd[g] = ram_pipe[L-1];
    end

    // ---------------------------------------------------------------
    // Reference model state
    // ---------------------------------------------------------------
    typedef struct packed {
        logic        rd;
        logic [11:0] d;
        logic        hs;
        logic        vs;
    } pipe_t;

    pipe_t       hist [6];
    bit          m_synced, m_bank, m_fs;
    logic [15:0] m_addr;

    int n_chk, n_fail, cyc, t_hin;
    logic prev_hin;
    logic prev_vh [N_INST];
    int   fs_cnt  [N_INST];
    int   ln_cnt  [N_INST];
    int   ln_first[N_INST];
    int   ln_last [N_INST];
    int   ln_b1   [N_INST];

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [inst %0d RD_LAT=%0d]: got %0d expected %0d (cycle %0d)",
                     name, k, lat_of[k], act, exp, cyc);
        end
    endtask

    // Apply one cycle of controller inputs, advance the model, compare every output
    task automatic tick(input int h, input int v, input bit disp);
        int    col, row;
        bit    rd;
        pipe_t x;
        hcounter = 9'(h);
        vcounter = 11'(v);
        display  = disp;
        hsync_in = !(h >= 216 && h < 240);
        vsync_in = !(v >= 601 && v <= 604);
        @(posedge clk);
        #1;
        cyc++;
        col = h - 1;
        row = v / 4;
        rd  = !rst && disp && m_synced && col >= 0 && col < 200 && row < 150;
        if (rst) begin
            m_synced = 0; m_bank = 0; m_fs = 0; m_addr = '0;
            for (int i = 0; i < 6; i++) hist[i] = '{rd: 1'b0, d: 12'h0, hs: 1'b1, vs: 1'b1};
        end else begin
            if (rd) m_addr = {m_bank, 15'(row * 200 + col)};
            m_fs = (h == 264 && v == 628);
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = '{rd: rd, d: m_addr[11:0], hs: hsync_in, vs: vsync_in};
            if (m_fs) begin
                m_synced = 1;
                m_bank   = buf_sel;
            end
        end
        if (prev_hin && !hsync_in) t_hin = cyc;
        prev_hin = hsync_in;
        for (int k = 0; k < N_INST; k++) begin
            x = hist[lat_of[k] + 1];
            chk("fb_rd_en",    k, int'(fre[k]), int'(rd));
            chk("fb_addr",     k, int'(fa[k]), int'(m_addr));
            chk("frame_start", k, int'(fs[k]), int'(m_fs));
            chk("active_bank", k, int'(ab[k]), int'(m_bank));
            chk("vga_rgb",     k, int'({vr[k], vg[k], vb[k]}), x.rd ? int'(x.d) : 0);
            chk("vga_hsync",   k, int'(vh[k]), int'(x.hs));
            chk("vga_vsync",   k, int'(vv[k]), int'(x.vs));
            if (prev_vh[k] && !vh[k] && t_hin > 0)
                chk("hsync_latency", k, cyc - (t_hin - 1), lat_of[k] + 2);
            prev_vh[k] = vh[k];
            if (fs[k]) fs_cnt[k]++;
            if (fre[k]) begin
                if (ln_cnt[k] == 0) ln_first[k] = int'(fa[k][14:0]);
                ln_last[k] = int'(fa[k][14:0]);
                if (fa[k][15]) ln_b1[k]++;
                ln_cnt[k]++;
            end
        end
    endtask

    task automatic clear_line_stats();
        for (int k = 0; k < N_INST; k++) begin
            ln_cnt[k] = 0; ln_first[k] = 0; ln_last[k] = 0; ln_b1[k] = 0;
        end
    endtask

    // Run one complete 265-cycle line, then check the reads it issued
    task automatic run_line(input int v, input int e_cnt, input int e_first,
                            input int e_last, input bit e_bank);
        clear_line_stats();
        for (int h = 0; h <= 264; h++) tick(h, v, (v < 600 && h >= 1 && h <= 200));
        for (int k = 0; k < N_INST; k++) begin
            chk("line_read_count", k, ln_cnt[k], e_cnt);
            if (e_cnt > 0) begin
                chk("line_first_addr", k, ln_first[k], e_first);
                chk("line_last_addr",  k, ln_last[k], e_last);
                chk("line_bank",       k, ln_b1[k], e_bank ? e_cnt : 0);
            end
        end
    endtask

    typedef struct {
        int v;
        int cnt;
        int first;
        int last;
        bit bank;
    } line_vec_t;

    typedef struct {
        int h;
        bit disp;
        bit exp_rd;
        int exp_addr;
    } col_vec_t;

    line_vec_t lines [6];
    col_vec_t  cols  [6];

    initial begin
        int idx;

        lines[0] = '{v: 0,   cnt: 200, first: 0,     last: 199,   bank: 1'b0};
        lines[1] = '{v: 3,   cnt: 200, first: 0,     last: 199,   bank: 1'b0};
        lines[2] = '{v: 4,   cnt: 200, first: 200,   last: 399,   bank: 1'b0};
        lines[3] = '{v: 599, cnt: 200, first: 29800, last: 29999, bank: 1'b0};
        lines[4] = '{v: 600, cnt: 0,   first: 0,     last: 0,     bank: 1'b0};
        lines[5] = '{v: 628, cnt: 0,   first: 0,     last: 0,     bank: 1'b0};

        cols[0] = '{h: 0,   disp: 1'b1, exp_rd: 1'b0, exp_addr: 0};
        cols[1] = '{h: 1,   disp: 1'b1, exp_rd: 1'b1, exp_addr: 0};
        cols[2] = '{h: 200, disp: 1'b1, exp_rd: 1'b1, exp_addr: 199};
        cols[3] = '{h: 201, disp: 1'b1, exp_rd: 1'b0, exp_addr: 0};
        cols[4] = '{h: 100, disp: 1'b0, exp_rd: 1'b0, exp_addr: 0};
        cols[5] = '{h: 150, disp: 1'b1, exp_rd: 1'b1, exp_addr: 149};

        n_chk = 0; n_fail = 0; cyc = 0; t_hin = 0;
        prev_hin = 1'b1;
        m_synced = 0; m_bank = 0; m_fs = 0; m_addr = '0;
        for (int i = 0; i < 6; i++) hist[i] = '{rd: 1'b0, d: 12'h0, hs: 1'b1, vs: 1'b1};
        for (int k = 0; k < N_INST; k++) begin
            prev_vh[k] = 1'b1; fs_cnt[k] = 0;
        end
        clear_line_stats();

        rst = 1'b1; buf_sel = 1'b0;
        hcounter = '0; vcounter = '0; display = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;

        // Reset state
        repeat (3) tick(0, 0, 1'b0);
        for (int k = 0; k < N_INST; k++) begin
            chk("reset_fb_addr",     k, int'(fa[k]), 0);
            chk("reset_fb_rd_en",    k, int'(fre[k]), 0);
            chk("reset_rgb",         k, int'({vr[k], vg[k], vb[k]}), 0);
            chk("reset_hsync",       k, int'(vh[k]), 1);
            chk("reset_vsync",       k, int'(vv[k]), 1);
            chk("reset_frame_start", k, int'(fs[k]), 0);
            chk("reset_active_bank", k, int'(ab[k]), 0);
        end
        rst = 1'b0;

        // First frame boundary brings the block into sync
        tick(264, 628, 1'b0);
        for (int k = 0; k < N_INST; k++) begin
            chk("first_frame_start", k, int'(fs[k]), 1);
            fs_cnt[k] = 0;
        end

        // Frame A: table-driven full lines; bank request flips at line 300
        for (int v = 0; v <= 628; v++) begin
            if (v == 300) buf_sel = 1'b1;
            if (v == 600) begin
                tick(5, 600, 1'b1);
                for (int k = 0; k < N_INST; k++) chk("blank_row_forced_display", k, int'(fre[k]), 0);
            end
            if (v == 628)
                for (int k = 0; k < N_INST; k++) chk("bank_before_boundary", k, int'(ab[k]), 0);
            idx = -1;
            for (int i = 0; i < 6; i++) if (lines[i].v == v) idx = i;
            if (idx >= 0) run_line(v, lines[idx].cnt, lines[idx].first, lines[idx].last, lines[idx].bank);
            else          tick(264, v, 1'b0);
        end
        for (int k = 0; k < N_INST; k++) begin
            chk("boundary_frame_start", k, int'(fs[k]), 1);
            chk("boundary_bank_switch", k, int'(ab[k]), 1);
            chk("frame_start_count",    k, fs_cnt[k], 1);
            fs_cnt[k] = 0;
        end

        // Frame B: bank 1, then a mid-frame reset at line 250
        for (int v = 0; v <= 628; v++) begin
            if (v == 0) begin
                run_line(0, 200, 0, 199, 1'b1);
            end else if (v == 250) begin
                for (int h = 0; h <= 264; h++) begin
                    rst = (h >= 50 && h <= 52);
                    if (h == 50) buf_sel = 1'b0;
                    if (h == 53) clear_line_stats();
                    tick(h, 250, (h >= 1 && h <= 200));
                end
                rst = 1'b0;
                for (int k = 0; k < N_INST; k++) begin
                    chk("post_reset_reads", k, ln_cnt[k], 0);
                    chk("post_reset_bank",  k, int'(ab[k]), 0);
                end
            end else if (v == 251) begin
                run_line(251, 0, 0, 0, 1'b0);
            end else begin
                tick(264, v, 1'b0);
            end
        end
        for (int k = 0; k < N_INST; k++) begin
            chk("resync_frame_start", k, int'(fs[k]), 1);
            chk("frame_start_count_b", k, fs_cnt[k], 1);
        end

        // Frame C: column-edge vectors on line 0, then the full first line
        for (int i = 0; i < 6; i++) begin
            tick(cols[i].h, 0, cols[i].disp);
            for (int k = 0; k < N_INST; k++) begin
                chk("col_rd_en", k, int'(fre[k]), int'(cols[i].exp_rd));
                if (cols[i].exp_rd) chk("col_addr", k, int'(fa[k]), cols[i].exp_addr);
            end
        end
        repeat (6) tick(0, 0, 1'b0);
        run_line(0, 200, 0, 199, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Pixel-fetch stage directly downstream of the display controller.
- Consumes its hcounter, vcounter, display, hsync and vsync outputs and generates read addresses into a 200x150 RGB444 framebuffer held in block RAM.
- Upscales each stored row vertically by VREP, so 150 stored rows fill 600 visible lines.
- Delays sync and display to match RAM latency, and drives blanked RGB plus sync to the VGA pins.
- Supports double buffering: the bank select is latched only at frame boundaries.

Parameters:
- FB_W, 200, framebuffer width in pixels.
- FB_H, 150, framebuffer height in stored rows.
- VREP, 4, display lines per stored row.
- V_VIS, 600, number of visible lines.
- H_FINISH, 264, hcounter value at the end of each line.
- V_FINISH, 628, vcounter value at the end of each frame.
- COL_OFFSET, 1, hcounter value that maps to column 0 while display=1.
- RD_LAT, 1, framebuffer read latency in cycles, from fb_addr/fb_rd_en registered to fb_data valid; legal range 1..4.
- ADDR_W, 15, address width per bank; 2^15 >= 30000.

Ports:
- clk  in  1  pixel clock, 10 MHz.
- rst  in  1  synchronous reset, active-high.
- hcounter  in  9  horizontal counter from the display controller.
- vcounter  in  11  vertical counter from the display controller.
- display  in  1  display enable from the display controller.
- hsync_in  in  1  active-low horizontal sync from the display controller.
- vsync_in  in  1  active-low vertical sync from the display controller.
- buf_sel  in  1  requested display bank; sampled at frame boundary only.
- fb_addr  out  ADDR_W+1  {bank, row*FB_W+col}; registered.
- fb_rd_en  out  1  read strobe; registered.
- fb_data  in  12  pixel from RAM, RD_LAT cycles after fb_rd_en; [11:8]=R, [7:4]=G, [3:0]=B.
- vga_r, vga_g, vga_b  out  4 each  pixel colour; 0 when blanked.
- vga_hsync, vga_vsync  out  1 each  delayed sync signals, active-low.
- frame_start  out  1  one-cycle pulse at each frame boundary.
- active_bank  out  1  bank currently being scanned out.

Behaviour:
- Reset values:
  - fb_addr=0, fb_rd_en=0, vga_r/g/b=0, frame_start=0, active_bank=0.
  - vga_hsync=1, vga_vsync=1.
  - All internal state cleared: line_base=0, rep=0, row=0, synced=0.
  - Delay pipeline flushed to display=0, syncs=1.
- End-of-line event (EOL): hcounter==H_FINISH. vcounter at EOL is the line just completed.
- Frame boundary: EOL with vcounter==V_FINISH. On the same edge:
  - line_base<=0, rep<=0, row<=0.
  - active_bank<=buf_sel.
  - synced<=1.
  - frame_start<=1 for exactly one cycle.
- Row stepping: EOL with vcounter<V_VIS and row<FB_H.
  - If rep==VREP-1: rep<=0, row<=row+1, line_base<=line_base+FB_W.
  - Otherwise: rep<=rep+1.
- The row counter saturates at FB_H; no further line_base growth.
- Stage 1 (address), registered every cycle:
  - col = hcounter-COL_OFFSET, computed in 10-bit signed arithmetic.
  - fb_rd_en <= display & synced & (0<=col<FB_W) & (row<FB_H).
  - fb_addr <= {active_bank, line_base+col[ADDR_W-1:0]} when fb_rd_en is set; otherwise fb_addr holds its previous value.
- Delay line: display_q, hsync, vsync and the computed rd_en are shifted through RD_LAT+1 register stages.
- Output stage, registered:
  - RGB = fb_data fields when the delayed rd_en is 1; otherwise 0.
  - vga_hsync/vga_vsync take the delayed sync values.
- Total latency: controller inputs to vga_* outputs = RD_LAT+2 cycles, identical for RGB and both syncs. Syncs must never be skewed relative to pixels.
- Reset mid-frame: synced=0 forces fb_rd_en=0 and black output until the next frame boundary. Syncs keep passing through after reset deasserts, with the pipeline delay.
- buf_sel changes mid-frame have no effect until the next boundary. No tearing is allowed.
- Columns outside 0..FB_W-1 while display=1 are blanked, never clamped or wrapped.
- Maximum address: row 149 * 200 + 199 = 29999. No access >= 30000 is allowed.

Test Plan:
- Reset then run 2 frames with buf_sel=0:
  - frame_start pulses once per frame.
  - The first visible pixel after sync reads fb_addr=0.
  - Line 0 reads 0..199; lines 0-3 repeat 0..199; line 4 reads 200..399.
- RAM model returns data=address[11:0]; RD_LAT swept over 1,2,4:
  - vga_r/g/b match the address issued RD_LAT+2 cycles after the corresponding hcounter.
  - vga_hsync falls exactly RD_LAT+2 cycles after hsync_in.
- Last visible line (vcounter=599):
  - Reads 29800..29999.
  - No fb_rd_en during vcounter 600..628.
  - RGB=0 throughout vertical blanking.
- Toggle buf_sel to 1 at vcounter=300:
  - fb_addr[15] stays 0 for the rest of the frame.
  - Becomes 1 from the next frame.
  - active_bank changes on the frame_start edge.
- Assert rst for 3 cycles at vcounter=250:
  - Outputs black and fb_rd_en=0 until the next frame boundary.
  - Syncs remain periodic.
  - The next frame starts at fb_addr=0.
- Force display=1 with hcounter=0 and hcounter=201 (col=-1, col=200):
  - fb_rd_en=0.
  - RGB=0 at the output.
